instr_mem_prog: RTL

//   Parametrised instruction memory for the miniMips fetch stage. It replaces the fixed 9-bit ROM.
//   - After reset, an internal sequencer fills every word with NO_OP.
//   - A handshaked program-load port writes words sequentially, starting from address 0.
//   - In run mode, instruction fetch has a registered read with stall.
//   - Sits between the PC register and the decoder; a testbench or boot loader drives the load port.

---
 rtl/instr_mem_prog.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_mem_prog.sv
// instr_mem_prog: programmable instruction memory for the miniMips fetch stage.
// After reset it self-clears to NO_OP, then serves registered fetches.
// A handshaked port can reload words sequentially from address 0.
module instr_mem_prog #(
  parameter int          DATA_W = 9,
  parameter int          ADDR_W = 8,
  parameter logic [DATA_W-1:0] NO_OP = 9'b101100100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] laddr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              done_nxt;
  logic              load_acc;

  assign busy       = (state != S_RUN);
  assign load_ready = (state == S_LOAD);
  assign load_acc   = load_valid && load_ready;

  // State register; reset always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  // Next state and write-port steering (clear sweep or load word)
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = NO_OP;
    done_nxt  = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (load_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_acc) begin
          mem_we    = 1'b1;
          mem_waddr = laddr;
          mem_wdata = load_data;
          if (load_last || laddr == LAST_ADDR) begin
            state_nxt = S_RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Clear/load address counters; both are only ever used up to LAST_ADDR
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      laddr <= '0;
    end else begin
      if (state == S_CLEAR) cnt <= cnt + 1'b1;
      if (state == S_RUN && load_start) laddr <= '0;
      else if (load_acc)                laddr <= laddr + 1'b1;
    end
  end

  // Storage write port; held off while reset is asserted
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  // Registered fetch with stall; load_done is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= NO_OP;
      instr_valid <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= done_nxt;
      if (state == S_RUN && fetch_en) begin
        instr       <= mem[pc];
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
